// File: rtl/call_stack_if.sv
// rtl/call_stack_if.sv - decode-stage request and status bundle for the call/return stack
interface call_stack_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int OPC_W  = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              enable;
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] din;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output enable, opcode, din, clr_err,
    input  dout, dout_valid, count, full, empty, overflow, underflow
  );

  modport slave (
    input  enable, opcode, din, clr_err,
    output dout, dout_valid, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/call_stack.sv
// rtl/call_stack.sv - parametrised LIFO of return addresses with full/empty status and sticky error flags
module call_stack #(
  parameter int               DATA_W   = 16,
  parameter int               DEPTH    = 8,
  parameter int               OPC_W    = 6,
  parameter logic [OPC_W-1:0] OPC_PUSH = 6'b000101,
  parameter logic [OPC_W-1:0] OPC_POP  = 6'b000100,
  parameter int               OVF_MODE = 0
) (
  input logic        clk,
  input logic        rst,
  call_stack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     top_q, top_d, top_m1;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push, pop, full_w, empty_w, do_write, do_read;

  assign push    = bus.enable && (bus.opcode == OPC_PUSH);
  assign pop     = bus.enable && (bus.opcode == OPC_POP);
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign top_m1  = top_q - AW'(1);

  // In overwrite mode a push while full still writes: top wraps onto the oldest entry.
  assign do_write = push && (!full_w || (OVF_MODE == 1));
  assign do_read  = pop && !empty_w;

  always_comb begin
    top_d        = top_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    ovf_d        = (ovf_q && !bus.clr_err) || (push && full_w);
    unf_d        = (unf_q && !bus.clr_err) || (pop && empty_w);
    if (do_write) begin
      top_d = top_q + AW'(1);
      if (!full_w) count_d = count_q + CW'(1);
    end else if (do_read) begin
      top_d        = top_m1;
      count_d      = count_q - CW'(1);
      dout_d       = mem_q[top_m1];
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q        <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      top_q        <= top_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  // Storage is deliberately left out of reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[top_q] <= bus.din;
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
endmodule

// File: doc/call_stack.md
# call_stack

Parametrised hardware call/return stack (LIFO) for the 16-bit core, replacing the single-entry stack-pointer register. It decodes push (store) and pop (load) opcodes from the decode stage and stores return addresses. Depth, data width and opcode encodings are configurable. It adds full/empty status, sticky overflow/underflow error flags and a selectable overflow policy.

## Interface
Parameters:
- DATA_W, 16, width of each stack entry (PC width)
- DEPTH, 8, number of entries; power of two, >= 2
- OPC_W, 6, opcode width
- OPC_PUSH, 6'b000101, opcode that pushes din
- OPC_POP, 6'b000100, opcode that pops to dout
- OVF_MODE, 0, overflow policy: 0 = drop push, 1 = overwrite oldest entry

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- enable  in  1  qualifies opcode; 0 = no operation this cycle
- opcode  in  OPC_W  instruction opcode, compared for exact equality
- din  in  DATA_W  value to push (current PC)
- clr_err  in  1  synchronous clear of overflow/underflow flags
- dout  out  DATA_W  last popped value, registered
- dout_valid  out  1  one-cycle pulse: dout updated by a successful pop
- count  out  $clog2(DEPTH+1)  number of valid entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH x DATA_W register array, circular index top (log2 DEPTH bits) pointing to the next free slot; count tracks occupancy.
- push = enable && opcode == OPC_PUSH; pop = enable && opcode == OPC_POP. Any other opcode, or enable = 0: state held, dout_valid = 0.
- Push, not full: mem[top] <= din; top <= top+1 (mod DEPTH); count <= count+1.
- Push, full, OVF_MODE=0: storage, top and count unchanged; overflow <= 1.
- Push, full, OVF_MODE=1: mem[top] <= din; top <= top+1 (mod DEPTH), overwriting the oldest entry; count stays DEPTH; overflow <= 1.
- Pop, not empty: dout <= mem[top-1]; top <= top-1 (mod DEPTH); count <= count-1; dout_valid <= 1.
- Pop, empty: dout holds; dout_valid <= 0; top and count unchanged; underflow <= 1.
- Push and pop are mutually exclusive by opcode decode; no simultaneous case exists.
- clr_err = 1 clears both sticky flags. A new error in the same cycle wins: the flag is set.
- full and empty are combinational from count.
- Reset (async, any time, including mid-sequence):
  - top = 0, count = 0, dout = 0, dout_valid = 0, overflow = 0, underflow = 0.
  - Hence full = 0, empty = 1.
  - Array contents are not reset and are unobservable until rewritten.

## Timing
- Push: entry written at edge N; count/full/empty reflect it after edge N.
- Pop: dout and dout_valid valid in the cycle after edge N (1-cycle latency); dout_valid deasserts next cycle unless another successful pop.
- Back-to-back push/pop every cycle supported; a pop directly after a push returns that pushed value.
- Error flags set on the same edge as the offending request.
- rst deassertion is synchronised externally; the first operation is accepted on the first rising edge with rst = 0.

## Test plan
- Reset then idle: after rst, count=0, empty=1, full=0, dout=16'h0000, all flags 0; enable=1 with opcode=6'b000000 for 3 cycles -> no change.
- LIFO order: push 16'h0001, 16'h0002, 16'h0003, then 3 pops -> dout 0003, 0002, 0001, each with a one-cycle dout_valid pulse; count 3->0, empty=1.
- Fill and overflow, OVF_MODE=0 and DEPTH=8:
  - Push 1..9 -> full=1 after the 8th push; the 9th push sets overflow and leaves count=8.
  - 8 pops -> 8..1.
- Overwrite, OVF_MODE=1 and DEPTH=8: push 1..10 -> overflow=1, count=8; 8 pops -> 10..3.
- Underflow and clear:
  - Pop when empty -> underflow=1, dout_valid=0, dout unchanged.
  - clr_err alone -> flag clears.
  - clr_err together with another empty pop -> underflow stays 1.
- Reset mid-operation: push 16'hABCD, 16'h1234, assert rst between clock edges -> immediately count=0, empty=1, dout=0; a following pop -> underflow=1.
